// File: rtl/maze_sequencer_if.sv
// Handshake/bus bundle between the maze game-flow controller and its neighbours.
// Optional MAZE_SEQ_LIVES_EN adds the lives_left field.
interface maze_sequencer_if;
    logic       start;
    logic       at_exit;
    logic       caught;
    logic       fade_ack;
    logic       clear;
    logic       increment;
    logic [2:0] maze_idx;
    logic       fade_req;
    logic       playing;
    logic       game_won;
    logic       game_over;
    logic       fade_timeout;
`ifdef MAZE_SEQ_LIVES_EN
    logic [1:0] lives_left;
`endif

    // Player/collision/fade side: drives the requests, observes the game state.
    modport master (
        output start, at_exit, caught, fade_ack,
        input  clear, increment, maze_idx, fade_req, playing, game_won, game_over, fade_timeout
`ifdef MAZE_SEQ_LIVES_EN
        , input lives_left
`endif
    );

    // Sequencer side.
    modport slave (
        input  start, at_exit, caught, fade_ack,
        output clear, increment, maze_idx, fade_req, playing, game_won, game_over, fade_timeout
`ifdef MAZE_SEQ_LIVES_EN
        , output lives_left
`endif
    );
endinterface

// File: rtl/maze_sequencer.sv
// Game-flow controller for the maze-index counter: clear/increment pulses,
// exit debounce, fade handshake with timeout, win/lose detection.
// Optional feature macro: MAZE_SEQ_LIVES_EN (lives register, lives_left output).
module maze_sequencer #(
    parameter int unsigned NUM_MAZES     = 5,
    parameter int unsigned EXIT_DEBOUNCE = 4,
    parameter int unsigned FADE_TIMEOUT  = 1023
) (
    input logic             clk,
    input logic             reset_n,
    maze_sequencer_if.slave bus
);

    localparam int unsigned DW = $clog2(EXIT_DEBOUNCE + 1);
    localparam int unsigned TW = $clog2(FADE_TIMEOUT + 1);
    localparam logic [2:0]    LAST_IDX = 3'(NUM_MAZES - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(EXIT_DEBOUNCE - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(FADE_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, PLAY, FADE, WIN, LOSE} state_t;

    state_t        state;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] to_cnt;
    logic [2:0]    maze_idx;
    logic          clear, increment, fade_req, playing, game_won, game_over, fade_timeout;
`ifdef MAZE_SEQ_LIVES_EN
    logic [1:0]    lives;
`endif

    // Game state machine; flags are decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        state_t nxt;
        if (!reset_n) begin
            state        <= IDLE;
            deb_cnt      <= '0;
            to_cnt       <= '0;
            maze_idx     <= 3'd0;
            clear        <= 1'b0;
            increment    <= 1'b0;
            fade_req     <= 1'b0;
            playing      <= 1'b0;
            game_won     <= 1'b0;
            game_over    <= 1'b0;
            fade_timeout <= 1'b0;
`ifdef MAZE_SEQ_LIVES_EN
            lives        <= 2'd0;
`endif
        end else begin
            nxt       = state;
            clear     <= 1'b0;
            increment <= 1'b0;
            case (state)
                IDLE, WIN, LOSE: begin
                    if (bus.start) begin
                        nxt          = PLAY;
                        clear        <= 1'b1;
                        maze_idx     <= 3'd0;
                        deb_cnt      <= '0;
                        fade_timeout <= 1'b0;
`ifdef MAZE_SEQ_LIVES_EN
                        lives        <= 2'd3;
`endif
                    end
                end
                PLAY: begin
                    if (bus.caught) begin
                        deb_cnt <= '0;
`ifdef MAZE_SEQ_LIVES_EN
                        if (lives > 2'd1) begin
                            lives <= lives - 2'd1;
                        end else begin
                            lives <= 2'd0;
                            nxt   = LOSE;
                        end
`else
                        nxt = LOSE;
`endif
                    end else if (bus.at_exit) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt <= '0;
                            to_cnt  <= '0;
                            nxt     = (maze_idx == LAST_IDX) ? WIN : FADE;
                        end else begin
                            deb_cnt <= deb_cnt + DW'(1);
                        end
                    end else begin
                        deb_cnt <= '0;
                    end
                end
                FADE: begin
                    if (bus.fade_ack || to_cnt == TO_LAST) begin
                        nxt       = PLAY;
                        increment <= 1'b1;
                        maze_idx  <= maze_idx + 3'd1;
                        deb_cnt   <= '0;
                        if (!bus.fade_ack) begin
                            fade_timeout <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: nxt = IDLE;
            endcase
            state     <= nxt;
            playing   <= (nxt == PLAY);
            fade_req  <= (nxt == FADE);
            game_won  <= (nxt == WIN);
            game_over <= (nxt == LOSE);
        end
    end

    assign bus.clear        = clear;
    assign bus.increment    = increment;
    assign bus.maze_idx     = maze_idx;
    assign bus.fade_req     = fade_req;
    assign bus.playing      = playing;
    assign bus.game_won     = game_won;
    assign bus.game_over    = game_over;
    assign bus.fade_timeout = fade_timeout;
`ifdef MAZE_SEQ_LIVES_EN
    assign bus.lives_left   = lives;
`endif

endmodule

// File: tb/tb_maze_sequencer.sv
// Directed bench for maze_sequencer with NUM_MAZES=5, EXIT_DEBOUNCE=4, FADE_TIMEOUT=16.
module tb_maze_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    maze_sequencer_if bus();

    maze_sequencer #(
        .NUM_MAZES    (5),
        .EXIT_DEBOUNCE(4),
        .FADE_TIMEOUT (16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.at_exit  = 1'b0;
        bus.caught   = 1'b0;
        bus.fade_ack = 1'b0;
        step();
        step();
        checks++;
        if ({bus.clear, bus.increment, bus.maze_idx, bus.fade_req, bus.playing,
             bus.game_won, bus.game_over, bus.fade_timeout} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: clr=%0b inc=%0b idx=%0d req=%0b play=%0b won=%0b over=%0b to=%0b, all required 0",
                     bus.clear, bus.increment, bus.maze_idx, bus.fade_req, bus.playing,
                     bus.game_won, bus.game_over, bus.fade_timeout);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (bus.playing !== 1'b0 || bus.clear !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: playing=%0b clear=%0b, required 0 0", bus.playing, bus.clear);
        end
    endtask

    task automatic test_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.clear !== 1'b1 || bus.playing !== 1'b1 || bus.maze_idx !== 3'd0) begin
            errors++;
            $display("FAIL start_clear: clear=%0b playing=%0b idx=%0d, required 1 1 0", bus.clear, bus.playing, bus.maze_idx);
        end
        step();
        checks++;
        if (bus.clear !== 1'b0 || bus.playing !== 1'b1) begin
            errors++;
            $display("FAIL clear_one_cycle: clear=%0b playing=%0b, required 0 1", bus.clear, bus.playing);
        end
    endtask

    task automatic test_debounce();
        bus.at_exit = 1'b1;
        repeat (3) step();
        bus.at_exit = 1'b0;
        step();
        step();
        checks++;
        if (bus.fade_req !== 1'b0 || bus.playing !== 1'b1) begin
            errors++;
            $display("FAIL short_exit: fade_req=%0b playing=%0b, required 0 1", bus.fade_req, bus.playing);
        end
        bus.at_exit = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.fade_req !== 1'b0) begin
            errors++;
            $display("FAIL exit_early: fade_req=%0b after 3 cycles, required 0", bus.fade_req);
        end
        step();
        bus.at_exit = 1'b0;
        checks++;
        if (bus.fade_req !== 1'b1 || bus.playing !== 1'b0) begin
            errors++;
            $display("FAIL exit_fade: fade_req=%0b playing=%0b, required 1 0", bus.fade_req, bus.playing);
        end
    endtask

    task automatic test_fade_ack();
        bus.caught    = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.caught    = 1'b0;
        bus.start     = 1'b0;
        checks++;
        if (bus.fade_req !== 1'b1 || bus.game_over !== 1'b0 || bus.clear !== 1'b0) begin
            errors++;
            $display("FAIL fade_ignores_inputs: req=%0b over=%0b clear=%0b, required 1 0 0",
                     bus.fade_req, bus.game_over, bus.clear);
        end
        repeat (9) step();
        bus.fade_ack = 1'b1;
        step();
        bus.fade_ack = 1'b0;
        checks++;
        if (bus.increment !== 1'b1 || bus.maze_idx !== 3'd1 || bus.playing !== 1'b1 ||
            bus.fade_req !== 1'b0 || bus.fade_timeout !== 1'b0) begin
            errors++;
            $display("FAIL fade_ack_inc: inc=%0b idx=%0d play=%0b req=%0b to=%0b, required 1 1 1 0 0",
                     bus.increment, bus.maze_idx, bus.playing, bus.fade_req, bus.fade_timeout);
        end
        step();
        checks++;
        if (bus.increment !== 1'b0) begin
            errors++;
            $display("FAIL inc_one_cycle: inc=%0b, required 0", bus.increment);
        end
        bus.fade_ack = 1'b1;
        step();
        bus.fade_ack = 1'b0;
        checks++;
        if (bus.increment !== 1'b0 || bus.maze_idx !== 3'd1) begin
            errors++;
            $display("FAIL ack_outside_fade: inc=%0b idx=%0d, required 0 1", bus.increment, bus.maze_idx);
        end
    endtask

    task automatic test_advance_to_win();
        for (int m = 1; m < 4; m++) begin
            bus.at_exit = 1'b1;
            repeat (4) step();
            bus.at_exit = 1'b0;
            checks++;
            if (bus.fade_req !== 1'b1) begin
                errors++;
                $display("FAIL advance_fade maze %0d: fade_req=%0b, required 1", m, bus.fade_req);
            end
            repeat (10) step();
            bus.fade_ack = 1'b1;
            step();
            bus.fade_ack = 1'b0;
            checks++;
            if (bus.increment !== 1'b1 || bus.maze_idx !== 3'(m + 1)) begin
                errors++;
                $display("FAIL advance_inc maze %0d: inc=%0b idx=%0d, required 1 %0d", m, bus.increment, bus.maze_idx, m + 1);
            end
            step();
        end
        bus.at_exit = 1'b1;
        repeat (4) step();
        bus.at_exit = 1'b0;
        checks++;
        if (bus.game_won !== 1'b1 || bus.fade_req !== 1'b0 || bus.playing !== 1'b0 || bus.increment !== 1'b0) begin
            errors++;
            $display("FAIL win: won=%0b req=%0b play=%0b inc=%0b, required 1 0 0 0",
                     bus.game_won, bus.fade_req, bus.playing, bus.increment);
        end
        step();
        checks++;
        if (bus.increment !== 1'b0 || bus.maze_idx !== 3'd4 || bus.game_won !== 1'b1) begin
            errors++;
            $display("FAIL win_hold: inc=%0b idx=%0d won=%0b, required 0 4 1", bus.increment, bus.maze_idx, bus.game_won);
        end
    endtask

    task automatic test_caught_priority();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.clear !== 1'b1 || bus.maze_idx !== 3'd0 || bus.playing !== 1'b1 || bus.game_won !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_win: clear=%0b idx=%0d play=%0b won=%0b, required 1 0 1 0",
                     bus.clear, bus.maze_idx, bus.playing, bus.game_won);
        end
        step();
        bus.at_exit = 1'b1;
        repeat (3) step();
        bus.caught = 1'b1;
        step();
        bus.at_exit = 1'b0;
        bus.caught  = 1'b0;
        checks++;
`ifdef MAZE_SEQ_LIVES_EN
        if (bus.game_over !== 1'b0 || bus.fade_req !== 1'b0 || bus.playing !== 1'b1 || bus.lives_left !== 2'd2) begin
            errors++;
            $display("FAIL caught_vs_exit: over=%0b req=%0b play=%0b lives=%0d, required 0 0 1 2",
                     bus.game_over, bus.fade_req, bus.playing, bus.lives_left);
        end
        bus.caught = 1'b1;
        repeat (2) step();
        bus.caught = 1'b0;
`else
        if (bus.game_over !== 1'b1 || bus.fade_req !== 1'b0 || bus.playing !== 1'b0) begin
            errors++;
            $display("FAIL caught_vs_exit: over=%0b req=%0b play=%0b, required 1 0 0",
                     bus.game_over, bus.fade_req, bus.playing);
        end
`endif
        step();
        checks++;
        if (bus.game_over !== 1'b1 || bus.fade_req !== 1'b0) begin
            errors++;
            $display("FAIL lose_hold: over=%0b req=%0b, required 1 0", bus.game_over, bus.fade_req);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.clear !== 1'b1 || bus.maze_idx !== 3'd0 || bus.playing !== 1'b1 || bus.game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_lose: clear=%0b idx=%0d play=%0b over=%0b, required 1 0 1 0",
                     bus.clear, bus.maze_idx, bus.playing, bus.game_over);
        end
        step();
    endtask

    task automatic test_timeout();
        bus.at_exit = 1'b1;
        repeat (4) step();
        bus.at_exit = 1'b0;
        checks++;
        if (bus.fade_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_enter: fade_req=%0b, required 1", bus.fade_req);
        end
        for (int k = 1; k < 16; k++) begin
            step();
            checks++;
            if (bus.increment !== 1'b0 || bus.fade_req !== 1'b1) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: inc=%0b req=%0b, required 0 1", k + 1, bus.increment, bus.fade_req);
            end
        end
        step();
        checks++;
        if (bus.increment !== 1'b1 || bus.fade_timeout !== 1'b1 || bus.maze_idx !== 3'd1 || bus.playing !== 1'b1) begin
            errors++;
            $display("FAIL timeout_inc: inc=%0b to=%0b idx=%0d play=%0b, required 1 1 1 1",
                     bus.increment, bus.fade_timeout, bus.maze_idx, bus.playing);
        end
        step();
        bus.caught = 1'b1;
        for (int i = 0; i < 3 && bus.game_over !== 1'b1; i++) step();
        bus.caught = 1'b0;
        checks++;
        if (bus.game_over !== 1'b1 || bus.fade_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: over=%0b to=%0b, required 1 1", bus.game_over, bus.fade_timeout);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.fade_timeout !== 1'b0 || bus.clear !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cleared: to=%0b clear=%0b, required 0 1", bus.fade_timeout, bus.clear);
        end
        step();
    endtask

    task automatic test_reset_mid_fade();
        bus.at_exit = 1'b1;
        repeat (4) step();
        bus.at_exit = 1'b0;
        step();
        checks++;
        if (bus.fade_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_fade_enter: fade_req=%0b, required 1", bus.fade_req);
        end
        bus.fade_ack = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.fade_req, bus.increment, bus.clear, bus.playing, bus.maze_idx} !== 7'd0) begin
            errors++;
            $display("FAIL mid_fade_reset: req=%0b inc=%0b clr=%0b play=%0b idx=%0d, all required 0",
                     bus.fade_req, bus.increment, bus.clear, bus.playing, bus.maze_idx);
        end
        step();
        bus.fade_ack = 1'b0;
        reset_n = 1'b1;
        step();
        checks++;
        if (bus.increment !== 1'b0 || bus.playing !== 1'b0 || bus.fade_req !== 1'b0) begin
            errors++;
            $display("FAIL after_mid_fade_reset: inc=%0b play=%0b req=%0b, required 0 0 0",
                     bus.increment, bus.playing, bus.fade_req);
        end
    endtask

`ifdef MAZE_SEQ_LIVES_EN
    task automatic test_lives();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.lives_left !== 2'd3) begin
            errors++;
            $display("FAIL lives_init: lives=%0d, required 3", bus.lives_left);
        end
        step();
        for (int i = 1; i <= 3; i++) begin
            bus.caught = 1'b1;
            step();
            bus.caught = 1'b0;
            checks++;
            if (bus.lives_left !== 2'(3 - i) || bus.maze_idx !== 3'd0 ||
                bus.game_over !== (i == 3) || bus.playing !== (i != 3) || bus.clear !== 1'b0) begin
                errors++;
                $display("FAIL lives_caught %0d: lives=%0d idx=%0d over=%0b play=%0b clr=%0b, required %0d 0 %0b %0b 0",
                         i, bus.lives_left, bus.maze_idx, bus.game_over, bus.playing, bus.clear,
                         3 - i, i == 3, i != 3);
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_debounce();
        test_fade_ack();
        test_advance_to_win();
        test_caught_priority();
        test_timeout();
        test_reset_mid_fade();
`ifdef MAZE_SEQ_LIVES_EN
        test_lives();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_sequencer.md
Name: maze_sequencer

Overview:
- Game-flow controller that drives the maze-index counter: issues its single-cycle clear and increment pulses and decides when the player advances, wins or loses.
- Sits between player/collision logic (exit reached, caught) and the display fade logic, using a req/ack handshake with the fade logic.
- Keeps a shadow copy of the maze index so the final maze can be detected without reading the counter back.

Parameters:
- NUM_MAZES, 5, number of mazes in a game; legal range 2..8 (3-bit index).
- EXIT_DEBOUNCE, 4, consecutive cycles at_exit must be high to count as an exit; legal range >=1.
- FADE_TIMEOUT, 1023, maximum cycles to wait for fade_ack before advancing anyway; legal range >=1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  start/restart request, level-sampled.
- at_exit  in  1  player sprite overlaps the exit tile of the current maze.
- caught  in  1  player collided with an enemy.
- fade_ack  in  1  display fade completed.
- clear  out  1  one-cycle pulse to the counter's clear input.
- increment  out  1  one-cycle pulse to the counter's increment input.
- maze_idx  out  3  shadow maze index; equals the counter output one cycle after each pulse.
- fade_req  out  1  request a fade transition.
- playing  out  1  high in PLAY.
- game_won  out  1  high in WIN.
- game_over  out  1  high in LOSE.
- fade_timeout  out  1  sticky flag: a fade ended by timeout; cleared on the next start.

Behaviour:
- Reset (async assert, sync release): state IDLE, maze_idx=0, debounce and timeout counters=0, all outputs 0.
- States: IDLE, PLAY, FADE, WIN, LOSE. Registered outputs decode from state; pulses are registered, so each pulse is exactly one cycle long.
- IDLE: start=1 -> clear pulse next cycle, maze_idx<=0, go to PLAY.
- PLAY: debounce counter increments while at_exit=1 and resets to 0 when at_exit=0.
  - Counter reaches EXIT_DEBOUNCE and maze_idx==NUM_MAZES-1 -> WIN.
  - Counter reaches EXIT_DEBOUNCE otherwise -> FADE, with fade_req=1 from the first FADE cycle.
  - caught=1 has priority over an exit completing in the same cycle -> LOSE.
  - start is ignored in PLAY.
- FADE: fade_req held high; at_exit, caught and start are ignored.
  - fade_ack=1 -> increment pulse, maze_idx<=maze_idx+1, fade_req drops, debounce counter cleared, return to PLAY.
  - No fade_ack after FADE_TIMEOUT cycles in FADE -> same transition, and fade_timeout<=1.
  - fade_ack seen outside FADE is ignored.
- WIN / LOSE: the matching flag is held high; start=1 -> clear pulse, maze_idx<=0, fade_timeout<=0, go to PLAY.
- maze_idx never exceeds NUM_MAZES-1; no wrap is possible because the last maze exits to WIN.
- clear and increment are never high in the same cycle.
- Reset mid-FADE: all outputs return to 0 immediately, including fade_req, and no pulse is issued.
- Latency: exit held from cycle t -> FADE entered at cycle t+EXIT_DEBOUNCE; fade_ack at cycle a -> increment high at cycle a+1.

Optional Feature:
- Macro MAZE_SEQ_LIVES_EN adds a 2-bit lives register, initialised to 3 on every clear pulse, and a 2-bit output lives_left.
- caught in PLAY with lives>1: lives decrements, debounce counter clears, state stays PLAY, maze_idx unchanged, no pulse.
- caught in PLAY with lives==1: lives<=0 and go to LOSE.
- Without the macro: no lives register and no lives_left port; caught always goes to LOSE.

Test Plan:
- Reset, start=1 for one cycle -> clear high for exactly one cycle, playing=1, maze_idx=0.
- NUM_MAZES=5, EXIT_DEBOUNCE=4; at_exit high 3 cycles then low, then high 4 cycles -> no fade_req after the 3-cycle pulse; fade_req=1 after the 4-cycle pulse.
- In FADE, assert fade_ack 10 cycles after fade_req -> one increment pulse, maze_idx 0->1, back in PLAY; repeat through maze 4, exit -> game_won=1, no fifth increment.
- caught and the completing at_exit cycle coincide -> game_over=1 and no fade_req; then start -> clear pulse, maze_idx=0, PLAY.
- FADE_TIMEOUT=16, fade_ack held low -> increment issued on the 17th cycle after entering FADE, fade_timeout=1; start after WIN/LOSE -> fade_timeout=0.
- With MAZE_SEQ_LIVES_EN: three caught pulses in PLAY -> lives_left 3->2->1, then game_over=1 with lives_left=0; maze_idx unchanged throughout.
